// File: rtl/half_dot_v_m_tiled.sv
// fp16 vector x matrix engine: HEIGHT output columns are time-multiplexed over
// LANES MAC units, with optional bias add and ReLU on write-back.
module half_dot_v_m_tiled #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int LANES  = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic                               bias_en,
    input  logic                               relu,
    input  logic [WIDTH-1:0][15:0]             vector,
    input  logic [WIDTH-1:0][HEIGHT-1:0][15:0] matrix,
    input  logic [HEIGHT-1:0][15:0]            bias,
    output logic                               busy,
    output logic                               done,
    output logic [HEIGHT-1:0][15:0]            vector_out
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_MAC  | one multiply-accumulate per lane per cycle, k = 0..WIDTH-1
    // S_WB   | bias/ReLU and write of the current tile's columns
    // S_DONE | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    localparam int TILES = (HEIGHT + LANES - 1) / LANES;
    localparam int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int CW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TILES - 1);
    localparam logic [15:0]   QNAN   = 16'h7E00;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [TW-1:0]             tile_q, tile_d;
    logic [WIDTH-1:0][15:0]    vec_q;
    logic                      bias_en_q, relu_q;
    logic [LANES-1:0][15:0]    acc_q, acc_d;
    logic [HEIGHT-1:0][15:0]   vout_q, vout_d;

    logic [LANES-1:0]          lane_act;
    logic [CW-1:0]             col_idx [LANES];
    logic [LANES-1:0][15:0]    mac_res, wb_sum, wb_res;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    // Rounds a normalised significand (hidden bit implied) and applies
    // overflow-to-Inf and flush-to-zero on the final exponent.
    function automatic logic [15:0] fp_round(input logic s, input int e,
                                             input logic [9:0] m,
                                             input logic g, input logic st);
        logic [10:0] mr;
        int          er;
        mr = {1'b0, m} + 11'(g & (st | m[0]));
        er = e;
        if (mr[10]) er = e + 1;
        if (er >= 31) return {s, 15'h7C00};
        if (er <= 0)  return {s, 15'h0000};
        return {s, er[4:0], mr[9:0]};
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        int          e;
        logic        a_inf, b_inf, a_zero, b_zero;
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        s = a[15] ^ b[15];
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (a_inf || b_inf) return (a_zero || b_zero) ? QNAN : {s, 15'h7C00};
        if (a_zero || b_zero) return {s, 15'h0000};
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) return fp_round(s, e + 1, p[20:11], p[10], |p[9:0]);
        return fp_round(s, e, p[19:10], p[9], |p[8:0]);
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [23:0] mx, my, lost;
        logic [24:0] sum;
        logic        st;
        int          d, e;
        logic        a_inf, b_inf, a_zero, b_zero;
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (a_inf && b_inf && (a[15] != b[15])) return QNAN;
        if (a_inf) return {a[15], 15'h7C00};
        if (b_inf) return {b[15], 15'h7C00};
        if (a_zero && b_zero) return {a[15] & b[15], 15'h0000};
        if (a_zero) return b;
        if (b_zero) return a;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = int'(x[14:10]) - int'(y[14:10]);
        mx = {1'b1, x[9:0], 13'h0};
        my = {1'b1, y[9:0], 13'h0};
        if (d > 24) begin
            st = 1'b1;
            my = '0;
        end else begin
            lost = my << (24 - d);
            st   = (lost != '0);
            my   = my >> d;
        end
        // Shifted-out bits are jammed into the LSB so RNE still sees them.
        my[0] = my[0] | st;
        sum = (x[15] ^ y[15]) ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        if (sum == '0) return 16'h0000;
        e = int'(x[14:10]);
        if (sum[24]) begin
            sum = {1'b0, sum[24:1]} | {24'h0, sum[0]};
            e   = e + 1;
        end else begin
            for (int i = 0; i < 23; i++) begin
                if (!sum[23]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        return fp_round(x[15], e, sum[22:13], sum[12], |sum[11:0]);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tile_q  <= tile_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tile_d  = tile_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    k_d     = '0;
                    tile_d  = '0;
                end
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    state_d = S_WB;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WB: begin
                if (tile_q == T_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MAC;
                    tile_d  = tile_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        vout_d = vout_q;
        for (int l = 0; l < LANES; l++) begin
            lane_act[l] = (int'(tile_q) * LANES + l) < HEIGHT;
            col_idx[l]  = lane_act[l] ? CW'(int'(tile_q) * LANES + l) : '0;
            // k == 0 restarts the accumulator from +0 for this tile.
            mac_res[l]  = fp_add((k_q == '0) ? 16'h0000 : acc_q[l],
                                 fp_mul(vec_q[k_q], matrix[k_q][col_idx[l]]));
            wb_sum[l]   = bias_en_q ? fp_add(acc_q[l], bias[col_idx[l]]) : acc_q[l];
            wb_res[l]   = (relu_q && wb_sum[l][15] && !is_nan(wb_sum[l])) ? 16'h0000
                                                                           : wb_sum[l];
            if (state_q == S_MAC) acc_d[l] = mac_res[l];
            if ((state_q == S_WB) && lane_act[l]) vout_d[col_idx[l]] = wb_res[l];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_q     <= '0;
            bias_en_q <= 1'b0;
            relu_q    <= 1'b0;
            acc_q     <= '0;
            vout_q    <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                vec_q     <= vector;
                bias_en_q <= bias_en;
                relu_q    <= relu;
            end
            acc_q  <= acc_d;
            vout_q <= vout_d;
        end
    end

    assign vector_out = vout_q;

endmodule

// File: tb/tb_half_dot_v_m_tiled.sv
// Directed bench for half_dot_v_m_tiled: WIDTH=4, HEIGHT=3 with LANES=2 as the
// main instance and LANES=1 / LANES=3 instances sharing the same inputs.
module tb_half_dot_v_m_tiled;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic                 bias_en = 1'b0;
    logic                 relu = 1'b0;
    logic [3:0][15:0]     vector = '0;
    logic [3:0][2:0][15:0] matrix = '0;
    logic [2:0][15:0]     bias = '0;
    logic                 busy1, busy2, busy3, done1, done2, done3;
    logic [2:0][15:0]     vout1, vout2, vout3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    half_dot_v_m_tiled #(.WIDTH(4), .HEIGHT(3), .LANES(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .bias_en(bias_en), .relu(relu),
        .vector(vector), .matrix(matrix), .bias(bias),
        .busy(busy2), .done(done2), .vector_out(vout2));

    half_dot_v_m_tiled #(.WIDTH(4), .HEIGHT(3), .LANES(1)) dut_l1 (
        .clk(clk), .rstn(rstn), .start(start), .bias_en(bias_en), .relu(relu),
        .vector(vector), .matrix(matrix), .bias(bias),
        .busy(busy1), .done(done1), .vector_out(vout1));

    half_dot_v_m_tiled #(.WIDTH(4), .HEIGHT(3), .LANES(3)) dut_l3 (
        .clk(clk), .rstn(rstn), .start(start), .bias_en(bias_en), .relu(relu),
        .vector(vector), .matrix(matrix), .bias(bias),
        .busy(busy3), .done(done3), .vector_out(vout3));

    task automatic fill(input logic [15:0] v, input logic [15:0] c0,
                        input logic [15:0] c1, input logic [15:0] c2);
        for (int i = 0; i < 4; i++) begin
            vector[i]    = v;
            matrix[i][0] = c0;
            matrix[i][1] = c1;
            matrix[i][2] = c2;
        end
    endtask

    task automatic launch(input logic r, input logic be);
        @(negedge clk);
        relu    = r;
        bias_en = be;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after the accepting edge) in which
    // done was seen on the main instance, or -1 if it never came.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40 && cyc < 0; c++) begin
            @(negedge clk);
            if (done2) cyc = c;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy2, done2);
        end
        checks++;
        if (vout2 !== 48'h0 || vout1 !== 48'h0 || vout3 !== 48'h0) begin
            errors++;
            $display("FAIL reset_vout got %h %h %h want 0", vout1, vout2, vout3);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int done_at;
        fill(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        launch(1'b0, 1'b0);
        done_at = -1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            checks++;
            if (busy2 !== (c <= 11)) begin
                errors++;
                $display("FAIL basic_busy cycle %0d got %b want %b", c, busy2, (c <= 11));
            end
            checks++;
            if (done2 !== (c == 11)) begin
                errors++;
                $display("FAIL basic_done cycle %0d got %b want %b", c, done2, (c == 11));
            end
            if (c == 11) begin
                checks++;
                if (vout2 !== 48'h4400_4400_4400) begin
                    errors++;
                    $display("FAIL basic_vout got %h want 440044004400", vout2);
                end
            end
        end
    endtask

    task automatic test_relu;
        int cyc;
        fill(16'h3C00, 16'h3C00, 16'hBC00, 16'h3800);
        launch(1'b0, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h4000_C400_4400) begin
            errors++;
            $display("FAIL relu_off got lat=%0d vout=%h want 11 4000c4004400", cyc, vout2);
        end
        launch(1'b1, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h4000_0000_4400) begin
            errors++;
            $display("FAIL relu_on got lat=%0d vout=%h want 11 400000004400", cyc, vout2);
        end
    endtask

    task automatic test_bias;
        int cyc;
        fill(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        bias[0] = 16'h4000;
        bias[1] = 16'hC400;
        bias[2] = 16'h0000;
        launch(1'b0, 1'b1);
        @(negedge clk);
        vector = '0;
        wait_done(cyc);
        checks++;
        if (cyc !== 10 || vout2 !== 48'h4400_0000_4600) begin
            errors++;
            $display("FAIL bias got lat=%0d vout=%h want 10 440000004600", cyc, vout2);
        end
        bias_en = 1'b0;
        bias    = '0;
    endtask

    task automatic test_special;
        int cyc;
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vector[0]    = 16'h7BFF;
        matrix[0][0] = 16'h4000;
        matrix[0][1] = 16'h4000;
        matrix[0][2] = 16'h4000;
        launch(1'b0, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h7C00_7C00_7C00) begin
            errors++;
            $display("FAIL overflow got lat=%0d vout=%h want 11 7c007c007c00", cyc, vout2);
        end
        vector[1] = 16'h7E00;
        launch(1'b0, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h7E00_7E00_7E00) begin
            errors++;
            $display("FAIL nan got lat=%0d vout=%h want 11 7e007e007e00", cyc, vout2);
        end
        launch(1'b1, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h7E00_7E00_7E00) begin
            errors++;
            $display("FAIL nan_relu got lat=%0d vout=%h want 11 7e007e007e00", cyc, vout2);
        end
    endtask

    task automatic test_back_to_back;
        fill(16'h3C00, 16'h3C00, 16'hBC00, 16'h3800);
        launch(1'b0, 1'b0);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            checks++;
            if (done2 !== (c == 11 || c == 23)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d got %b want %b", c, done2, (c == 11 || c == 23));
            end
            if (c == 12 || c == 13) begin
                checks++;
                if (busy2 !== (c == 13)) begin
                    errors++;
                    $display("FAIL b2b_busy cycle %0d got %b want %b", c, busy2, (c == 13));
                end
            end
            if (c == 11 || c == 23) begin
                checks++;
                if (vout2 !== 48'h4000_C400_4400) begin
                    errors++;
                    $display("FAIL b2b_vout cycle %0d got %h want 4000c4004400", c, vout2);
                end
            end
            start = (c == 3 || c == 11 || c == 12);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        int seen;
        fill(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        launch(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || vout2 !== 48'h0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b done=%b vout=%h want 0 0 0", busy2, done2, vout2);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done2 || busy2) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen);
        end
        fill(16'h3C00, 16'h3C00, 16'hBC00, 16'h3800);
        launch(1'b0, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || vout2 !== 48'h4000_C400_4400) begin
            errors++;
            $display("FAIL after_reset got lat=%0d vout=%h want 11 4000c4004400", cyc, vout2);
        end
    endtask

    task automatic test_lanes;
        int d1, d3;
        repeat (20) @(negedge clk);
        fill(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        launch(1'b0, 1'b0);
        d1 = -1;
        d3 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done1 && d1 < 0) d1 = c;
            if (done3 && d3 < 0) d3 = c;
        end
        checks++;
        if (d1 !== 16 || vout1 !== 48'h4400_4400_4400) begin
            errors++;
            $display("FAIL lanes1 got lat=%0d vout=%h want 16 440044004400", d1, vout1);
        end
        checks++;
        if (d3 !== 6 || vout3 !== 48'h4400_4400_4400) begin
            errors++;
            $display("FAIL lanes3 got lat=%0d vout=%h want 6 440044004400", d3, vout3);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_relu;
        test_bias;
        test_special;
        test_back_to_back;
        test_reset_mid;
        test_lanes;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
